dma_psdpram_wr_arb: RTL and testbench
=====================================

DMA_PSDPRAM_WR_ARB -- requirements
Module: dma_psdpram_wr_arb

Interface
REQ-001 SHALL have parameter PORTS, default 2: number of write requesters sharing the RAM write port.
REQ-002 SHALL have parameter SEG_COUNT, default 2: RAM segment count.
REQ-003 SHALL have parameter SEG_DATA_WIDTH, default 128: segment data width.
REQ-004 SHALL have parameter SEG_BE_WIDTH, default SEG_DATA_WIDTH/8: segment byte-enable width.
REQ-005 SHALL have parameter SEG_ADDR_WIDTH, default 8: segment address width.
REQ-006 SHALL have parameter DONE_FIFO_DEPTH, default 4 (power of two, >=2): outstanding writes tracked per segment.
REQ-007 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port s_wr_cmd_be, input, PORTS*SEG_COUNT*SEG_BE_WIDTH: requester byte enables, port-major then segment.
REQ-010 SHALL have port s_wr_cmd_addr, input, PORTS*SEG_COUNT*SEG_ADDR_WIDTH: requester segment addresses.
REQ-011 SHALL have port s_wr_cmd_data, input, PORTS*SEG_COUNT*SEG_DATA_WIDTH: requester write data.
REQ-012 SHALL have port s_wr_cmd_valid, input, PORTS*SEG_COUNT: requester command valid, per port per segment.
REQ-013 SHALL have port s_wr_cmd_ready, output, PORTS*SEG_COUNT: requester command accepted.
REQ-014 SHALL have port s_wr_done, output, PORTS*SEG_COUNT: one-cycle completion pulse routed to the issuing requester.
REQ-015 SHALL have ports m_wr_cmd_be/addr/data, outputs, SEG_COUNT times SEG_BE_WIDTH/SEG_ADDR_WIDTH/SEG_DATA_WIDTH: RAM write command.
REQ-016 SHALL have ports m_wr_cmd_valid (output), m_wr_cmd_ready (input), m_wr_done (input), each SEG_COUNT wide: RAM write handshake and completion.

Function
REQ-017 SHALL arbitrate each segment independently; segment n grants never depend on any other segment.
REQ-018 SHALL grant per segment round-robin: highest priority is the port following the last port whose command transferred on that segment; after reset port 0 is highest.
REQ-019 SHALL forward the granted port's be/addr/data combinationally (zero-cycle latency); m_wr_cmd_valid[n] = any s_wr_cmd_valid for segment n AND done FIFO n not full.
REQ-020 SHALL assert s_wr_cmd_ready[p*SEG_COUNT+n] only for the granted port p, equal to m_wr_cmd_ready[n] AND FIFO n not full; non-granted ports see ready low.
REQ-021 SHALL, on transfer (m_wr_cmd_valid[n] AND m_wr_cmd_ready[n]), push the granted port index into done FIFO n and advance the round-robin pointer in the same edge.
REQ-022 SHALL, when m_wr_done[n] is high and FIFO n non-empty, pop the head index p and pulse s_wr_done[p*SEG_COUNT+n] combinationally in that cycle.
REQ-023 SHALL ignore m_wr_done[n] when FIFO n is empty (no s_wr_done pulse, no state change).
REQ-024 SHALL support simultaneous push and pop on a FIFO in one cycle; occupancy unchanged.
REQ-025 SHALL block new commands on segment n while FIFO n holds DONE_FIFO_DEPTH entries, even if a pop occurs that cycle.
REQ-026 SHALL not alter the grant while a requester holds valid without ready; grant changes only after a transfer or valid deassertion.
REQ-027 SHALL keep FIFO pointers one bit wider than log2(DONE_FIFO_DEPTH) and wrap modulo 2*DEPTH; full = MSBs differ, low bits equal.

Reset
REQ-028 SHALL, while rst is high, clear all FIFOs to empty, set all round-robin pointers to port 0, and drive m_wr_cmd_valid, s_wr_cmd_ready and s_wr_done all zero.
REQ-029 SHALL discard outstanding completions on reset mid-operation; m_wr_done pulses arriving after reset generate no s_wr_done.

Structure
REQ-030 SHALL need no shared package; all widths derive from module parameters.
REQ-031 SHALL instantiate one sub-module per segment, dma_psdpram_wr_arb_seg, holding the round-robin arbiter, mux and done FIFO.

Verification
REQ-032 SHALL cover: ports 0 and 1 both valid on segment 0 continuously, m_ready=1 -> grants alternate 0,1,0,1; s_wr_done follows to matching port one cycle after each RAM write.
REQ-033 SHALL cover: m_wr_cmd_ready[0]=0 for 5 cycles with port 1 valid -> port 1 grant held, addr/data stable, no transfer, no pointer change.
REQ-034 SHALL cover: m_wr_done[0] held low, 5 commands offered, DEPTH=4 -> exactly 4 accepted, 5th waits until a done pops.
REQ-035 SHALL cover: port 0 on segment 0 and port 1 on segment 1 same cycle -> both transfer same cycle, dones routed to s_wr_done[0] and s_wr_done[3].
REQ-036 SHALL cover: rst asserted with 3 outstanding entries, then m_wr_done pulses -> no s_wr_done; next grant goes to port 0.
REQ-037 SHALL cover: spurious m_wr_done[1] with empty FIFO -> no s_wr_done pulse, occupancy stays 0.

Source files
------------

// File: rtl/dma_psdpram_wr_arb_seg.sv
// One RAM segment: round-robin arbiter, zero-latency command mux and a done FIFO that routes completions back to the issuing port.
// Zero-cycle latency; commands stall when m_ready is low or the done FIFO is full, and a stalled grant stays with its requester.
module dma_psdpram_wr_arb_seg #(
    parameter int PORTS           = 2,
    parameter int SEG_DATA_WIDTH  = 128,
    parameter int SEG_BE_WIDTH    = SEG_DATA_WIDTH/8,
    parameter int SEG_ADDR_WIDTH  = 8,
    parameter int DONE_FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORTS*SEG_BE_WIDTH-1:0]    req_be,
    input  logic [PORTS*SEG_ADDR_WIDTH-1:0]  req_addr,
    input  logic [PORTS*SEG_DATA_WIDTH-1:0]  req_data,
    input  logic [PORTS-1:0]                 req_valid,
    output logic [PORTS-1:0]                 req_ready,
    output logic [PORTS-1:0]                 req_done,
    output logic [SEG_BE_WIDTH-1:0]          m_be,
    output logic [SEG_ADDR_WIDTH-1:0]        m_addr,
    output logic [SEG_DATA_WIDTH-1:0]        m_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    input  logic                             m_done
);
    localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int FW = $clog2(DONE_FIFO_DEPTH);

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] lock_idx;
    logic          locked;
    logic [IW-1:0] grant;
    logic          any_valid;
    int            cand;

    logic [IW-1:0] fifo_mem [DONE_FIFO_DEPTH];
    logic [FW:0]   wr_ptr;
    logic [FW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          xfer;
    logic          pop;

    // A requester stalled by the RAM keeps its grant until it transfers or drops valid.
    always_comb begin
        grant     = rr_ptr;
        cand      = 0;
        any_valid = |req_valid;
        if (locked && req_valid[lock_idx]) begin
            grant = lock_idx;
        end else begin
            for (int i = PORTS-1; i >= 0; i--) begin
                cand = (int'(rr_ptr) + i) % PORTS;
                if (req_valid[cand]) grant = IW'(cand);
            end
        end
    end

    assign full  = (wr_ptr[FW] != rd_ptr[FW]) && (wr_ptr[FW-1:0] == rd_ptr[FW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign m_valid = !rst && any_valid && !full;
    assign xfer    = m_valid && m_ready;
    assign pop     = !rst && m_done && !empty;

    assign m_be   = req_be[int'(grant)*SEG_BE_WIDTH +: SEG_BE_WIDTH];
    assign m_addr = req_addr[int'(grant)*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH];
    assign m_data = req_data[int'(grant)*SEG_DATA_WIDTH +: SEG_DATA_WIDTH];

    always_comb begin
        req_ready = '0;
        req_done  = '0;
        if (!rst && any_valid && m_ready && !full) req_ready[grant] = 1'b1;
        if (pop) req_done[fifo_mem[rd_ptr[FW-1:0]]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            lock_idx <= '0;
            locked   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            locked   <= m_valid && !m_ready;
            lock_idx <= grant;
            if (xfer) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (grant == IW'(PORTS-1)) ? '0 : grant + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Payload storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (xfer) fifo_mem[wr_ptr[FW-1:0]] <= grant;
    end
endmodule

// File: rtl/dma_psdpram_wr_arb.sv
// Shares the segmented RAM write port among PORTS requesters, each segment arbitrated independently.
// Zero-cycle command path; per-segment backpressure from m_wr_cmd_ready and the outstanding-write limit.
module dma_psdpram_wr_arb #(
    parameter int PORTS           = 2,
    parameter int SEG_COUNT       = 2,
    parameter int SEG_DATA_WIDTH  = 128,
    parameter int SEG_BE_WIDTH    = SEG_DATA_WIDTH/8,
    parameter int SEG_ADDR_WIDTH  = 8,
    parameter int DONE_FIFO_DEPTH = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [PORTS*SEG_COUNT*SEG_BE_WIDTH-1:0]   s_wr_cmd_be,
    input  logic [PORTS*SEG_COUNT*SEG_ADDR_WIDTH-1:0] s_wr_cmd_addr,
    input  logic [PORTS*SEG_COUNT*SEG_DATA_WIDTH-1:0] s_wr_cmd_data,
    input  logic [PORTS*SEG_COUNT-1:0]                s_wr_cmd_valid,
    output logic [PORTS*SEG_COUNT-1:0]                s_wr_cmd_ready,
    output logic [PORTS*SEG_COUNT-1:0]                s_wr_done,
    output logic [SEG_COUNT*SEG_BE_WIDTH-1:0]         m_wr_cmd_be,
    output logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0]       m_wr_cmd_addr,
    output logic [SEG_COUNT*SEG_DATA_WIDTH-1:0]       m_wr_cmd_data,
    output logic [SEG_COUNT-1:0]                      m_wr_cmd_valid,
    input  logic [SEG_COUNT-1:0]                      m_wr_cmd_ready,
    input  logic [SEG_COUNT-1:0]                      m_wr_done
);
    for (genvar n = 0; n < SEG_COUNT; n++) begin : g_seg
        logic [PORTS*SEG_BE_WIDTH-1:0]   seg_be;
        logic [PORTS*SEG_ADDR_WIDTH-1:0] seg_addr;
        logic [PORTS*SEG_DATA_WIDTH-1:0] seg_data;
        logic [PORTS-1:0]                seg_valid;
        logic [PORTS-1:0]                seg_ready;
        logic [PORTS-1:0]                seg_done;

        // Regroup the port-major buses so each segment sees only its own lanes.
        for (genvar p = 0; p < PORTS; p++) begin : g_port
            localparam int L = p*SEG_COUNT + n;
            assign seg_be[p*SEG_BE_WIDTH +: SEG_BE_WIDTH]       = s_wr_cmd_be[L*SEG_BE_WIDTH +: SEG_BE_WIDTH];
            assign seg_addr[p*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH] = s_wr_cmd_addr[L*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH];
            assign seg_data[p*SEG_DATA_WIDTH +: SEG_DATA_WIDTH] = s_wr_cmd_data[L*SEG_DATA_WIDTH +: SEG_DATA_WIDTH];
            assign seg_valid[p]     = s_wr_cmd_valid[L];
            assign s_wr_cmd_ready[L] = seg_ready[p];
            assign s_wr_done[L]      = seg_done[p];
        end

        dma_psdpram_wr_arb_seg #(
            .PORTS           (PORTS),
            .SEG_DATA_WIDTH  (SEG_DATA_WIDTH),
            .SEG_BE_WIDTH    (SEG_BE_WIDTH),
            .SEG_ADDR_WIDTH  (SEG_ADDR_WIDTH),
            .DONE_FIFO_DEPTH (DONE_FIFO_DEPTH)
        ) u_seg (
            .clk       (clk),
            .rst       (rst),
            .req_be    (seg_be),
            .req_addr  (seg_addr),
            .req_data  (seg_data),
            .req_valid (seg_valid),
            .req_ready (seg_ready),
            .req_done  (seg_done),
            .m_be      (m_wr_cmd_be[n*SEG_BE_WIDTH +: SEG_BE_WIDTH]),
            .m_addr    (m_wr_cmd_addr[n*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH]),
            .m_data    (m_wr_cmd_data[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH]),
            .m_valid   (m_wr_cmd_valid[n]),
            .m_ready   (m_wr_cmd_ready[n]),
            .m_done    (m_wr_done[n])
        );
    end
endmodule

// File: tb/tb_dma_psdpram_wr_arb.sv
// Directed bench for dma_psdpram_wr_arb with a queue-based reference model compared every cycle.
module tb_dma_psdpram_wr_arb;
    localparam int P  = 2;
    localparam int S  = 2;
    localparam int DW = 16;
    localparam int BW = 2;
    localparam int AW = 8;
    localparam int D  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [P*S*BW-1:0] s_wr_cmd_be;
    logic [P*S*AW-1:0] s_wr_cmd_addr;
    logic [P*S*DW-1:0] s_wr_cmd_data;
    logic [P*S-1:0]    s_wr_cmd_valid;
    logic [P*S-1:0]    s_wr_cmd_ready;
    logic [P*S-1:0]    s_wr_done;
    logic [S*BW-1:0]   m_wr_cmd_be;
    logic [S*AW-1:0]   m_wr_cmd_addr;
    logic [S*DW-1:0]   m_wr_cmd_data;
    logic [S-1:0]      m_wr_cmd_valid;
    logic [S-1:0]      m_wr_cmd_ready;
    logic [S-1:0]      m_wr_done;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    dma_psdpram_wr_arb #(
        .PORTS(P), .SEG_COUNT(S), .SEG_DATA_WIDTH(DW), .SEG_BE_WIDTH(BW),
        .SEG_ADDR_WIDTH(AW), .DONE_FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst),
        .s_wr_cmd_be(s_wr_cmd_be), .s_wr_cmd_addr(s_wr_cmd_addr), .s_wr_cmd_data(s_wr_cmd_data),
        .s_wr_cmd_valid(s_wr_cmd_valid), .s_wr_cmd_ready(s_wr_cmd_ready), .s_wr_done(s_wr_done),
        .m_wr_cmd_be(m_wr_cmd_be), .m_wr_cmd_addr(m_wr_cmd_addr), .m_wr_cmd_data(m_wr_cmd_data),
        .m_wr_cmd_valid(m_wr_cmd_valid), .m_wr_cmd_ready(m_wr_cmd_ready), .m_wr_done(m_wr_done)
    );

    function automatic logic [AW-1:0] addr_of(input int p, input int n);
        return AW'(16*(p+1) + n);
    endfunction
    function automatic logic [DW-1:0] data_of(input int p, input int n);
        return DW'(32'hA000 + 16*p + n);
    endfunction
    function automatic logic [BW-1:0] be_of(input int p, input int n);
        return BW'(p*2 + n);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: per-segment queue of outstanding issuers, next-priority port and a held grant.
    int q [S][$];
    int prio [S];
    bit lk [S];
    int lkp [S];
    int g_m [S];
    bit mv_m [S];
    bit xf_m [S];
    bit pp_m [S];
    logic [P*S-1:0] e_ready;
    logic [P*S-1:0] e_done;
    logic [S-1:0]   e_mv;

    initial begin
        for (int n = 0; n < S; n++) begin
            prio[n] = 0; lk[n] = 0; lkp[n] = 0;
        end
    end

    always begin
        @(negedge clk);
        e_ready = '0; e_done = '0; e_mv = '0;
        for (int n = 0; n < S; n++) begin
            g_m[n] = -1;
            if (lk[n] && s_wr_cmd_valid[lkp[n]*S+n]) g_m[n] = lkp[n];
            else
                for (int i = 0; i < P; i++)
                    if (g_m[n] < 0 && s_wr_cmd_valid[((prio[n]+i)%P)*S+n]) g_m[n] = (prio[n]+i)%P;
            mv_m[n] = !rst && g_m[n] >= 0 && q[n].size() < D;
            xf_m[n] = mv_m[n] && m_wr_cmd_ready[n];
            pp_m[n] = !rst && m_wr_done[n] && q[n].size() > 0;
            e_mv[n] = mv_m[n];
            if (mv_m[n] && m_wr_cmd_ready[n]) e_ready[g_m[n]*S+n] = 1'b1;
            if (pp_m[n]) e_done[q[n][0]*S+n] = 1'b1;
        end
        chk("m_valid", 32'(m_wr_cmd_valid), 32'(e_mv));
        chk("s_ready", 32'(s_wr_cmd_ready), 32'(e_ready));
        chk("s_done", 32'(s_wr_done), 32'(e_done));
        for (int n = 0; n < S; n++) begin
            if (mv_m[n]) begin
                chk("m_addr", 32'(m_wr_cmd_addr[n*AW +: AW]), 32'(addr_of(g_m[n], n)));
                chk("m_data", 32'(m_wr_cmd_data[n*DW +: DW]), 32'(data_of(g_m[n], n)));
                chk("m_be", 32'(m_wr_cmd_be[n*BW +: BW]), 32'(be_of(g_m[n], n)));
            end
        end
        @(posedge clk);
        for (int n = 0; n < S; n++) begin
            if (rst) begin
                q[n].delete(); prio[n] = 0; lk[n] = 0;
            end else begin
                if (pp_m[n]) void'(q[n].pop_front());
                if (xf_m[n]) begin
                    q[n].push_back(g_m[n]);
                    prio[n] = (g_m[n] + 1) % P;
                    lk[n] = 0;
                end else begin
                    lk[n] = mv_m[n];
                    lkp[n] = g_m[n];
                end
            end
        end
    end

    logic [3:0] t1_rdy [4];
    logic [3:0] t1_done [4];
    int acc;

    initial begin
        for (int p = 0; p < P; p++)
            for (int n = 0; n < S; n++) begin
                s_wr_cmd_be[(p*S+n)*BW +: BW]   = be_of(p, n);
                s_wr_cmd_addr[(p*S+n)*AW +: AW] = addr_of(p, n);
                s_wr_cmd_data[(p*S+n)*DW +: DW] = data_of(p, n);
            end
        rst = 1'b1; s_wr_cmd_valid = 4'b0101; m_wr_cmd_ready = 2'b11; m_wr_done = 2'b11;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mvalid", 32'(m_wr_cmd_valid), 0);
            chk("rst_ready", 32'(s_wr_cmd_ready), 0);
            chk("rst_done", 32'(s_wr_done), 0);
            cyc();
        end

        // Two ports contending on segment 0: alternating grants, completions one cycle later.
        rst = 1'b0; s_wr_cmd_valid = 4'b0101; m_wr_done = 2'b01;
        t1_rdy  = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        t1_done = '{4'b0000, 4'b0001, 4'b0100, 4'b0001};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("alt_ready", 32'(s_wr_cmd_ready), 32'(t1_rdy[k]));
            chk("alt_done", 32'(s_wr_done), 32'(t1_done[k]));
            cyc();
        end
        s_wr_cmd_valid = '0;
        @(negedge clk);
        chk("alt_last_done", 32'(s_wr_done), 32'h4);
        cyc();
        m_wr_done = '0;

        // RAM stall with port 1 granted; port 0 arriving later must not steal the grant.
        m_wr_cmd_ready = 2'b10; s_wr_cmd_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) s_wr_cmd_valid = 4'b0101;
            @(negedge clk);
            chk("stall_ready", 32'(s_wr_cmd_ready), 0);
            chk("stall_mvalid", 32'(m_wr_cmd_valid[0]), 1);
            chk("stall_addr", 32'(m_wr_cmd_addr[7:0]), 32'h20);
            cyc();
        end
        m_wr_cmd_ready = 2'b11;
        @(negedge clk);
        chk("release_ready", 32'(s_wr_cmd_ready), 32'h4);
        cyc();
        @(negedge clk);
        chk("next_ready", 32'(s_wr_cmd_ready), 32'h1);
        cyc();
        s_wr_cmd_valid = '0; m_wr_done = 2'b01;
        repeat (3) cyc();
        m_wr_done = '0;

        // Done FIFO fills at depth 4; a pop in the full cycle still blocks.
        s_wr_cmd_valid = 4'b0001; acc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (s_wr_cmd_ready[0]) acc++;
            cyc();
        end
        chk("fill_count", 32'(acc), 4);
        m_wr_done = 2'b01;
        @(negedge clk);
        chk("full_pop_ready", 32'(s_wr_cmd_ready), 0);
        chk("full_pop_mvalid", 32'(m_wr_cmd_valid[0]), 0);
        cyc();
        m_wr_done = '0;
        @(negedge clk);
        chk("after_pop_ready", 32'(s_wr_cmd_ready), 32'h1);
        cyc();
        s_wr_cmd_valid = '0; m_wr_done = 2'b01;
        repeat (5) cyc();
        m_wr_done = '0;

        // Independent segments transfer in the same cycle.
        s_wr_cmd_valid = 4'b1001;
        @(negedge clk);
        chk("dual_ready", 32'(s_wr_cmd_ready), 32'h9);
        cyc();
        s_wr_cmd_valid = '0; m_wr_done = 2'b11;
        @(negedge clk);
        chk("dual_done", 32'(s_wr_done), 32'h9);
        cyc();
        m_wr_done = '0;

        // Reset with three outstanding writes discards them and restores port 0 priority.
        s_wr_cmd_valid = 4'b0100; cyc(); cyc();
        s_wr_cmd_valid = 4'b0001; cyc();
        s_wr_cmd_valid = '0; rst = 1'b1;
        @(negedge clk);
        chk("midrst_mvalid", 32'(m_wr_cmd_valid), 0);
        cyc();
        rst = 1'b0; m_wr_done = 2'b11;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_done", 32'(s_wr_done), 0);
            cyc();
        end
        m_wr_done = '0; s_wr_cmd_valid = 4'b0101;
        @(negedge clk);
        chk("postrst_grant", 32'(s_wr_cmd_ready), 32'h1);
        cyc();
        s_wr_cmd_valid = '0; m_wr_done = 2'b01;
        @(negedge clk);
        chk("postrst_done1", 32'(s_wr_done), 32'h1);
        cyc();

        // Spurious completion on an empty segment is ignored.
        m_wr_done = 2'b10;
        @(negedge clk);
        chk("spurious_done", 32'(s_wr_done), 0);
        cyc();
        m_wr_done = '0; s_wr_cmd_valid = 4'b1000;
        @(negedge clk);
        chk("seg1_ready", 32'(s_wr_cmd_ready), 32'h8);
        cyc();
        s_wr_cmd_valid = '0; m_wr_done = 2'b10;
        @(negedge clk);
        chk("seg1_done", 32'(s_wr_done), 32'h8);
        cyc();
        @(negedge clk);
        chk("seg1_empty_done", 32'(s_wr_done), 0);
        cyc();
        m_wr_done = '0;
        repeat (3) cyc();

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end
endmodule
